// File: rtl/inst_loader.sv
// Instruction-memory loader: assembles 32-bit words from debounced byte entries
// (least-significant byte first) and writes them to consecutive word addresses.
module inst_loader #(
    parameter int ADDR_W          = 8,     // must be >= 6 for the LED address field
    parameter int LAST_ADDR       = 255,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Button,
    input  logic [7:0]        Data_in,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              Done,
    output logic [7:0]        LED
);
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [15:0]       DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic              sync_a;
    logic              sync_b;
    logic              btn_db;
    logic              btn_db_next;
    logic              press;
    logic [15:0]       db_cnt;
    logic [15:0]       db_cnt_next;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_idx_next;
    logic [31:0]       word;
    logic [31:0]       word_next;
    logic [ADDR_W-1:0] addr_next;

    // Debounce: the level flips only after the synchronised input has disagreed for the full window.
    always_comb begin
        btn_db_next = btn_db;
        db_cnt_next = 16'd0;
        if (sync_b != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db_next = sync_b;
                db_cnt_next = 16'd0;
            end else begin
                db_cnt_next = db_cnt + 16'd1;
            end
        end else begin
            db_cnt_next = 16'd0;
        end
    end

    // Button synchroniser, debounce state and rising-edge press pulse.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            btn_db <= 1'b0;
            db_cnt <= 16'd0;
            press  <= 1'b0;
        end else begin
            sync_a <= Button;
            sync_b <= sync_a;
            btn_db <= btn_db_next;
            db_cnt <= db_cnt_next;
            press  <= btn_db_next & ~btn_db;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (press && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end else begin
                    state_next = COLLECT;
                end
            end
            WRITE: begin
                if (addra == ADDR_LAST) begin
                    state_next = FULL;
                end else begin
                    state_next = COLLECT;
                end
            end
            FULL:    state_next = FULL;
            default: state_next = COLLECT;
        endcase
    end

    // Datapath next values: byte capture in COLLECT, address advance at the end of WRITE.
    always_comb begin
        byte_idx_next = byte_idx;
        word_next     = word;
        addr_next     = addra;
        case (state)
            COLLECT: begin
                if (press) begin
                    word_next[{byte_idx, 3'b000} +: 8] = Data_in;
                    byte_idx_next = byte_idx + 2'd1;
                end else begin
                    byte_idx_next = byte_idx;
                end
            end
            WRITE: begin
                if (addra != ADDR_LAST) begin
                    addr_next = addra + ADDR_ONE;
                end else begin
                    addr_next = addra;
                end
            end
            FULL:    addr_next = addra;
            default: addr_next = addra;
        endcase
    end

    // Registered datapath and status outputs, aligned with the state register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            byte_idx <= 2'd0;
            word     <= 32'd0;
            addra    <= '0;
            wea      <= 1'b0;
            Done     <= 1'b0;
            LED      <= 8'd0;
        end else begin
            byte_idx <= byte_idx_next;
            word     <= word_next;
            addra    <= addr_next;
            wea      <= (state_next == WRITE);
            Done     <= (state_next == FULL);
            LED      <= {byte_idx_next, addr_next[5:0]};
        end
    end

    assign dina = word;

endmodule
